// File: rtl/vc_read_arbiter.sv
// Two-VC read arbiter: weighted VC0/VC1 grant, 2-cycle registered delivery
// pipeline, pause backpressure and a sticky error flag.
module vc_read_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int VC0_WEIGHT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_fifo_VC0,
   input  logic                  empty_fifo_VC1,
   input  logic                  error_VC0,
   input  logic                  error_VC1,
   input  logic [DATA_WIDTH-1:0] data_out_VC0,
   input  logic [DATA_WIDTH-1:0] data_out_VC1,
   input  logic                  pause,
   output logic                  rd_enable_VC0,
   output logic                  rd_enable_VC1,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  vc_id_out,
   output logic                  idle_out,
   output logic                  error_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(VC0_WEIGHT);

   state_t                state_reg, state_next;
   logic [3:0]            streak_reg, streak_next;
   logic                  tag_valid_reg, tag_vc_reg;
   logic                  read_ok, grant_vc0, grant_vc1;
   logic                  any_pending, all_empty;
   logic [1:0]            vc_empty;
   logic [DATA_WIDTH-1:0] vc_data [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_vc
         assign vc_empty[gi] = (gi == 0) ? empty_fifo_VC0 : empty_fifo_VC1;
         assign vc_data[gi]  = (gi == 0) ? data_out_VC0   : data_out_VC1;
      end
   endgenerate

   assign all_empty   = &vc_empty;
   assign any_pending = ~all_empty;

   // Gating with reset keeps the strobes low even before the async clear settles.
   assign read_ok   = reset && (state_reg == ACTIVE) && !pause;
   assign grant_vc1 = read_ok && !vc_empty[1] && (vc_empty[0] || (streak_reg == STREAK_MAX));
   assign grant_vc0 = read_ok && !vc_empty[0] && !grant_vc1;

   assign rd_enable_VC0 = grant_vc0;
   assign rd_enable_VC1 = grant_vc1;
   assign idle_out      = (state_reg == IDLE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pause)
               state_next = PAUSE;
            else if (any_pending)
               state_next = ACTIVE;
         end
         ACTIVE: begin
            if (pause)
               state_next = PAUSE;
            else if (all_empty)
               state_next = IDLE;
         end
         PAUSE: begin
            if (!pause)
               state_next = any_pending ? ACTIVE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Streak only counts VC0 wins that actually starved a waiting VC1.
   always_comb begin
      streak_next = streak_reg;
      if (empty_fifo_VC1 || grant_vc1)
         streak_next = 4'd0;
      else if (grant_vc0 && (streak_reg < STREAK_MAX))
         streak_next = streak_reg + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         streak_reg <= 4'd0;
      end else begin
         state_reg  <= state_next;
         streak_reg <= streak_next;
      end
   end

   // Stage 1 tags the read while the FIFO registers its word; stage 2 forwards it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_valid_reg <= 1'b0;
         tag_vc_reg    <= 1'b0;
      end else begin
         tag_valid_reg <= grant_vc0 || grant_vc1;
         tag_vc_reg    <= grant_vc1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         vc_id_out <= 1'b0;
      end else begin
         valid_out <= tag_valid_reg;
         if (tag_valid_reg) begin
            data_out  <= vc_data[tag_vc_reg];
            vc_id_out <= tag_vc_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         error_out <= 1'b0;
      else if (error_VC0 || error_VC1)
         error_out <= 1'b1;
   end

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Scoreboard bench for vc_read_arbiter: queue-like FIFO models feed the DUT,
// a spec-level reference predicts grants/deliveries, a monitor compares them.
module tb_vc_read_arbiter;

   localparam int DW = 6;
   localparam int W  = 3;
   localparam int N  = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          empty_fifo_VC0, empty_fifo_VC1;
   logic          error_VC0 = 1'b0, error_VC1 = 1'b0;
   logic [DW-1:0] fdata0 = '0, fdata1 = '0;
   logic          pause = 1'b0;
   logic          rd_enable_VC0, rd_enable_VC1;
   logic [DW-1:0] data_out;
   logic          valid_out, vc_id_out, idle_out, error_out;

   always #5 clk = ~clk;

   vc_read_arbiter #(.DATA_WIDTH(DW), .VC0_WEIGHT(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .empty_fifo_VC0 (empty_fifo_VC0),
      .empty_fifo_VC1 (empty_fifo_VC1),
      .error_VC0      (error_VC0),
      .error_VC1      (error_VC1),
      .data_out_VC0   (fdata0),
      .data_out_VC1   (fdata1),
      .pause          (pause),
      .rd_enable_VC0  (rd_enable_VC0),
      .rd_enable_VC1  (rd_enable_VC1),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .vc_id_out      (vc_id_out),
      .idle_out       (idle_out),
      .error_out      (error_out)
   );

   // FIFO environment: written by stimulus (wr side) and by the clock (rd side)
   logic [DW-1:0] mem0 [N];
   logic [DW-1:0] mem1 [N];
   int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

   assign empty_fifo_VC0 = (wr0 == rd0);
   assign empty_fifo_VC1 = (wr1 == rd1);

   always @(posedge clk) begin
      if (!reset) begin
         rd0 <= wr0;
         rd1 <= wr1;
      end else begin
         if (rd_enable_VC0 && (wr0 != rd0)) begin
            fdata0 <= mem0[rd0 % N];
            rd0    <= rd0 + 1;
         end
         if (rd_enable_VC1 && (wr1 != rd1)) begin
            fdata1 <= mem1[rd1 % N];
            rd1    <= rd1 + 1;
         end
      end
   end

   // Reference model: per-cycle expectations plus delivery schedule
   int            cyc = 0;
   logic          exp_v [N];
   logic [DW-1:0] exp_d [N];
   logic          exp_c [N];
   logic          e_rd0 = 1'b0, e_rd1 = 1'b0, e_idle = 1'b1, e_err = 1'b0;
   logic          timeout_flag = 1'b0;

   typedef enum int {M_IDLE, M_ACTIVE, M_PAUSE} mode_t;

   initial begin
      mode_t mode;
      int    streak;
      bit    err_seen, e0, e1, reading, g0, g1;
      mode = M_IDLE;
      streak = 0;
      err_seen = 0;
      for (int i = 0; i < N; i++) exp_v[i] = 1'b0;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         exp_v[(cyc + 3) % N] = 1'b0;
         if (!reset) begin
            mode = M_IDLE;
            streak = 0;
            err_seen = 0;
            e_rd0 = 1'b0;
            e_rd1 = 1'b0;
            e_idle = 1'b1;
            e_err = 1'b0;
            for (int k = 0; k < 3; k++) exp_v[(cyc + k) % N] = 1'b0;
         end else begin
            e0 = empty_fifo_VC0;
            e1 = empty_fifo_VC1;
            e_idle = (mode == M_IDLE);
            e_err = err_seen;
            reading = (mode == M_ACTIVE) && !pause;
            g1 = reading && !e1 && (e0 || streak == W);
            g0 = reading && !e0 && !g1;
            e_rd0 = g0;
            e_rd1 = g1;
            if (g0 || g1) begin
               exp_v[(cyc + 2) % N] = 1'b1;
               exp_d[(cyc + 2) % N] = g1 ? mem1[rd1 % N] : mem0[rd0 % N];
               exp_c[(cyc + 2) % N] = g1;
            end
            if (e1 || g1) streak = 0;
            else if (g0 && streak < W) streak = streak + 1;
            if (error_VC0 || error_VC1) err_seen = 1;
            case (mode)
               M_IDLE:   if (pause) mode = M_PAUSE; else if (!e0 || !e1) mode = M_ACTIVE;
               M_ACTIVE: if (pause) mode = M_PAUSE; else if (e0 && e1) mode = M_IDLE;
               default:  if (!pause) mode = (e0 && e1) ? M_IDLE : M_ACTIVE;
            endcase
         end
      end
   end

   // Monitor: the only place comparisons are made
   int tests_run = 0;
   int tests_failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests_run++;
      if (act !== expv) begin
         tests_failed++;
         $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
      end
   endtask

   initial begin
      logic [DW-1:0] last_d;
      logic          last_c;
      int            idx;
      last_d = '0;
      last_c = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         idx = cyc % N;
         if (!reset) begin
            last_d = '0;
            last_c = 1'b0;
         end
         chk("rd_enable_VC0", 32'(rd_enable_VC0), 32'(e_rd0));
         chk("rd_enable_VC1", 32'(rd_enable_VC1), 32'(e_rd1));
         chk("idle_out", 32'(idle_out), 32'(e_idle));
         chk("error_out", 32'(error_out), 32'(e_err));
         chk("drain_timeout", 32'(timeout_flag), 32'd0);
         if (exp_v[idx]) begin
            chk("valid_out", 32'(valid_out), 32'd1);
            chk("data_out", 32'(data_out), 32'(exp_d[idx]));
            chk("vc_id_out", 32'(vc_id_out), 32'(exp_c[idx]));
            last_d = exp_d[idx];
            last_c = exp_c[idx];
            $display("[TB] cycle %0d delivered vc%0d data 0x%0h", cyc, vc_id_out, data_out);
         end else begin
            chk("valid_out_idle", 32'(valid_out), 32'd0);
            chk("data_out_hold", 32'(data_out), 32'(last_d));
            chk("vc_id_out_hold", 32'(vc_id_out), 32'(last_c));
         end
      end
   end

   // Stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [DW-1:0] d);
      mem0[wr0 % N] = d;
      wr0++;
   endtask

   task automatic push1(input logic [DW-1:0] d);
      mem1[wr1 % N] = d;
      wr1++;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      pause = 1'b0;
      while ((wr0 != rd0 || wr1 != rd1 || !idle_out) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) timeout_flag = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      int n;
      #1 reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;

      // both FIFOs empty: nothing happens
      repeat (10) tick();

      // three VC0 words
      push0(6'h01); push0(6'h02); push0(6'h03);
      wait_drain();

      // both loaded: weighted interleave
      for (int i = 0; i < 8; i++) begin
         push0(DW'(6'h10 + i));
         push1(DW'(6'h20 + i));
      end
      wait_drain();

      // pause with five VC0 words outstanding
      for (int i = 0; i < 10; i++) push0(DW'(6'h30 + i));
      n = 0;
      while ((wr0 - rd0) != 5 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) timeout_flag = 1'b1;
      pause = 1'b1;
      repeat (6) tick();
      pause = 1'b0;
      wait_drain();

      // sticky error
      error_VC1 = 1'b1;
      tick();
      error_VC1 = 1'b0;
      repeat (5) tick();

      // random traffic
      repeat (400) begin
         if ((wr0 - rd0) < 20 && $urandom_range(0, 2) == 0)
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) push0(DW'($urandom));
         if ((wr1 - rd1) < 20 && $urandom_range(0, 2) == 0)
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) push1(DW'($urandom));
         pause = ($urandom_range(0, 4) == 0);
         tick();
      end
      pause = 1'b0;

      // reset between edges while streaming
      for (int i = 0; i < 6; i++) begin
         push0(DW'($urandom));
         push1(DW'($urandom));
      end
      repeat (4) tick();
      #2 reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (10) tick();

      // random traffic with occasional errors
      repeat (400) begin
         if ((wr0 - rd0) < 20 && $urandom_range(0, 2) == 0)
            push0(DW'($urandom));
         if ((wr1 - rd1) < 20 && $urandom_range(0, 1) == 0)
            push1(DW'($urandom));
         pause = ($urandom_range(0, 6) == 0);
         error_VC0 = ($urandom_range(0, 249) == 0);
         tick();
      end
      error_VC0 = 1'b0;
      wait_drain();

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vc_read_arbiter.md
VC_READ_ARBITER -- requirements
Module: vc_read_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6, width of each VC word.
REQ-002 Parameter VC0_WEIGHT, default 3, max consecutive VC0 grants while VC1 is non-empty (range 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 empty_fifo_VC0  input  1  VC0 FIFO empty flag.
REQ-006 empty_fifo_VC1  input  1  VC1 FIFO empty flag.
REQ-007 error_VC0  input  1  VC0 FIFO count-overflow flag.
REQ-008 error_VC1  input  1  VC1 FIFO count-overflow flag.
REQ-009 data_out_VC0  input  DATA_WIDTH  VC0 FIFO registered read data.
REQ-010 data_out_VC1  input  DATA_WIDTH  VC1 FIFO registered read data.
REQ-011 pause  input  1  downstream backpressure; high inhibits new reads.
REQ-012 rd_enable_VC0  output  1  read strobe to VC0 FIFO (combinational).
REQ-013 rd_enable_VC1  output  1  read strobe to VC1 FIFO (combinational).
REQ-014 data_out  output  DATA_WIDTH  forwarded word (registered).
REQ-015 valid_out  output  1  data_out holds a new word this cycle (registered).
REQ-016 vc_id_out  output  1  source VC of data_out: 0=VC0, 1=VC1 (registered).
REQ-017 idle_out  output  1  high when FSM in IDLE.
REQ-018 error_out  output  1  sticky error indication.

Function
REQ-019 FSM states IDLE, ACTIVE, PAUSE, 2-bit encoded.
- IDLE -> ACTIVE: pause low and either empty flag low; IDLE -> PAUSE: pause high.
- ACTIVE -> PAUSE: pause high; ACTIVE -> IDLE: pause low and both empty flags high.
- PAUSE -> ACTIVE: pause low and either non-empty; PAUSE -> IDLE: pause low and both empty.
REQ-020 Reads issued only when state==ACTIVE and pause low; at most one of rd_enable_VC0/VC1 high per cycle; never asserted toward a FIFO whose empty flag is high.
REQ-021 Grant VC1 when VC1 non-empty and (VC0 empty or streak==VC0_WEIGHT); otherwise grant VC0 when VC0 non-empty.
REQ-022 streak: 4-bit counter; cleared on VC1 grant or when empty_fifo_VC1 high; incremented on VC0 grant while VC1 non-empty, saturating at VC0_WEIGHT.
REQ-023 Read latency: rd_enable at cycle t -> FIFO data valid after edge t+1 -> data_out/vc_id_out/valid_out updated at edge t+2 (2-cycle pipeline, 1 word/cycle sustained).
REQ-024 Pipeline holds a 2-stage valid/vc tag; in-flight words (max 2) are delivered even if pause rises or FSM leaves ACTIVE.
REQ-025 valid_out low in any cycle with no delivered word; data_out and vc_id_out hold last value when valid_out low.
REQ-026 error_out set on any cycle with error_VC0 or error_VC1 high; cleared only by reset.
REQ-027 pause and empty flags sampled combinationally the same cycle as the read decision; empty flags from the FIFOs reflect a read on the following cycle.

Reset
REQ-028 reset low forces immediately, without clk: state=IDLE, streak=0, pipeline valid tags=0, data_out=0, valid_out=0, vc_id_out=0, error_out=0.
REQ-029 rd_enable_VC0/VC1 low while reset low; idle_out high while reset low.
REQ-030 reset asserted mid-transfer discards in-flight words; no valid_out pulse after reset release until a new read is issued.

Verification
REQ-031 VC0 holds 3 words (0x01,0x02,0x03), VC1 empty, pause low -> rd_enable_VC0 high 3 consecutive cycles, valid_out high 3 cycles starting 2 cycles after first read, data 0x01,0x02,0x03, vc_id_out=0, then IDLE.
REQ-032 Both FIFOs hold 8 words, VC0_WEIGHT=3 -> grant sequence VC0,VC0,VC0,VC1 repeating until VC0 drains, then VC1 only.
REQ-033 pause raised in ACTIVE with 5 words left in VC0 -> rd_enable low the same cycle, exactly the ≤2 in-flight words delivered, FSM=PAUSE; pause lowered -> reads resume, all 5 remaining words delivered in order.
REQ-034 Both FIFOs empty at start -> no rd_enable ever, idle_out stays high, valid_out stays low.
REQ-035 error_VC1 pulsed one cycle -> error_out high from next edge and stays high until reset low.
REQ-036 reset driven low between clock edges during streaming -> all outputs reach reset values before the next edge; after release with FIFOs empty, valid_out stays 0.
